// File: rtl/text_pkg.sv
// Shared constants, FSM encoding and cell-address helper for the 80x30
// character-cell text buffer.
package text_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] CLEAR_CHAR = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] PRINT_MIN  = 8'h20;
  localparam logic [7:0] PRINT_MAX  = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

  // row*80 + col without a multiplier
  function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    logic [11:0] r;
    r = {6'd0, row};
    return (r << 6) + (r << 4) + {5'd0, col};
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port 2400x8 character RAM: write port A, synchronous
// read-first port B, written so that it maps onto a block RAM.
module text_ram
  import text_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [7:0]  wdata,
  input  logic [11:0] raddr,
  output logic [7:0]  rdata
);

  logic [7:0] mem [0:CELLS-1];

  // Both ports in one block so a same-cell access returns the old contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character-cell screen memory: accepts ASCII over valid/ready, manages the
// cursor and clears, and serves the cell under the VGA beam to the renderer.
module text_buffer
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [7:0] wr_ascii,
  output logic       wr_ready,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] ascii_add,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);

  state_t      state;
  logic [11:0] clr_addr;
  logic [6:0]  clr_col;
  logic        blank;

  logic        we;
  logic [11:0] waddr;
  logic [7:0]  wdata;
  logic [11:0] raddr;
  logic [7:0]  rdata;

  logic        is_print;
  logic        row_last;
  logic [6:0]  rd_col;
  logic [5:0]  rd_row;
  logic        rd_valid;
  logic        unused_xy;

  assign wr_ready = (state == IDLE);
  assign is_print = (wr_ascii >= PRINT_MIN) && (wr_ascii <= PRINT_MAX);
  assign row_last = (cursor_row == 5'(ROWS - 1));

  assign rd_col    = x[9:3];
  assign rd_row    = y[9:4];
  assign rd_valid  = video_on && (rd_col < 7'(COLS)) && (rd_row < 6'(ROWS));
  assign raddr     = rd_valid ? cell_addr(rd_row, rd_col) : 12'd0;
  assign unused_xy = ^{x[2:0], y[3:0]};

  // Write-port steering: clears, printable stores and backspace erase
  always_comb begin
    we    = 1'b0;
    waddr = 12'd0;
    wdata = CLEAR_CHAR;
    case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = clr_addr;
      end
      CLEAR_ROW: begin
        we    = 1'b1;
        waddr = cell_addr({1'b0, cursor_row}, clr_col);
      end
      IDLE: begin
        if (wr_valid) begin
          if (is_print) begin
            we    = 1'b1;
            waddr = cell_addr({1'b0, cursor_row}, cursor_col);
            wdata = wr_ascii;
          end else if (wr_ascii == ASCII_BS && cursor_col != 7'd0) begin
            we    = 1'b1;
            waddr = cell_addr({1'b0, cursor_row}, cursor_col - 7'd1);
          end else begin
            we = 1'b0;
          end
        end else begin
          we = 1'b0;
        end
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

  // Control FSM: clear sweeps, cursor movement and row wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR_ALL;
      clr_addr   <= 12'd0;
      clr_col    <= 7'd0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
    end else begin
      case (state)
        CLEAR_ALL: begin
          if (clr_addr == 12'(CELLS - 1)) begin
            clr_addr <= 12'd0;
            state    <= IDLE;
          end else begin
            clr_addr <= clr_addr + 12'd1;
          end
        end
        CLEAR_ROW: begin
          if (clr_col == 7'(COLS - 1)) begin
            clr_col <= 7'd0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end
        IDLE: begin
          if (wr_valid) begin
            if (is_print && cursor_col < 7'(COLS - 1)) begin
              cursor_col <= cursor_col + 7'd1;
            end else if (is_print || wr_ascii == ASCII_CR) begin
              cursor_col <= 7'd0;
              if (!row_last) begin
                cursor_row <= cursor_row + 5'd1;
              end else begin
                // Scrolling is not supported: wrap to the top and blank it
                cursor_row <= 5'd0;
                clr_col    <= 7'd0;
                state      <= CLEAR_ROW;
              end
            end else if (wr_ascii == ASCII_BS && cursor_col != 7'd0) begin
              cursor_col <= cursor_col - 7'd1;
            end
          end
        end
        default: begin
          state <= CLEAR_ALL;
        end
      endcase
    end
  end

  // Remembers whether the sampled pixel was off-screen or blanked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank <= 1'b1;
    end else begin
      blank <= !rd_valid;
    end
  end

  assign ascii_add = blank ? CLEAR_CHAR : rdata;

  text_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character-cell screen memory for the 640x480 text display, sitting directly upstream of the ASCII pixel renderer.
- Accepts ASCII codes from the keyboard/decoder path over a valid/ready handshake and stores them at a managed cursor position.
- Concurrently looks up the character under the current VGA pixel (x, y) and presents it on ascii_add to the renderer.
- Screen geometry: 80 columns x 30 rows of 8x16 cells.

Parameters:
- COLS, 80: characters per row (cell width 8 px).
- ROWS, 30: character rows (cell height 16 px).
- CLEAR_CHAR, 8'h20: fill code used by all clear operations.

Ports:
- clk  in  1  system pixel clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  a character is offered on wr_ascii.
- wr_ascii  in  8  offered ASCII code.
- wr_ready  out  1  buffer can accept a character this cycle.
- video_on  in  1  VGA active-video flag.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- ascii_add  out  8  character code for the cell containing (x, y), registered.
- cursor_col  out  7  current cursor column, 0..COLS-1.
- cursor_row  out  5  current cursor row, 0..ROWS-1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n is low: wr_ready=0, ascii_add=8'h20, cursor_col=0, cursor_row=0, FSM=CLEAR_ALL, clr_addr=0.
- Cell address: addr = row*80 + col, computed as (row<<6)+(row<<4)+col. Width is 12 bits; the maximum value is 2399.
- FSM states: CLEAR_ALL, IDLE, CLEAR_ROW.
- CLEAR_ALL:
  - Writes CLEAR_CHAR to addr clr_addr each cycle; clr_addr increments.
  - After the write to 2399, go to IDLE. This takes exactly 2400 cycles.
  - wr_ready=0 throughout.
- IDLE:
  - wr_ready=1.
  - A transfer occurs on a rising edge with wr_valid && wr_ready.
  - wr_ready is combinational from state only; it never depends on wr_valid.
- Transfer decode:
  - 8'h20..8'h7E (printable): write the code at (cursor_row, cursor_col).
    - If cursor_col < COLS-1: cursor_col+1.
    - Otherwise: cursor_col=0 and advance the row (see row advance).
  - 8'h0D (CR): cursor_col=0; advance the row.
  - 8'h08 (BS):
    - If cursor_col > 0: cursor_col-1, and write CLEAR_CHAR at the new position in the same cycle.
    - If cursor_col = 0: no effect.
  - All other codes: consumed (handshake completes) with no effect.
- Row advance:
  - If cursor_row < ROWS-1: cursor_row+1.
  - Otherwise: cursor_row=0, enter CLEAR_ROW for row 0.
- CLEAR_ROW:
  - Writes CLEAR_CHAR to the 80 cells of cursor_row, col 0..79, one per cycle; then returns to IDLE.
  - Takes exactly 80 cycles; wr_ready=0 throughout.
- Read path:
  - col = x[9:3], row = y[9:4].
  - ascii_add is updated 1 clock after x/y are sampled (synchronous RAM read). The renderer compensates for this latency.
  - If col >= COLS, row >= ROWS, or video_on=0 at sampling: ascii_add=8'h20 on the next cycle.
- Simultaneous read/write to the same cell: the read returns the old contents (read-first). The new value is visible on the following read.
- Reset asserted mid-clear or mid-transfer: all state returns to the reset values immediately. The full 2400-cycle CLEAR_ALL restarts on release.
- Cursor outputs update on the same edge as the accepted transfer.

Decomposition:
- Shared package text_pkg holds:
  - COLS, ROWS, CLEAR_CHAR.
  - Codes ASCII_CR=8'h0D, ASCII_BS=8'h08, PRINT_MIN=8'h20, PRINT_MAX=8'h7E.
  - CELLS=2400.
  - FSM state encoding {CLEAR_ALL, IDLE, CLEAR_ROW}.
- One sub-module, text_ram: simple dual-port 2400x8 RAM (write port A, synchronous read-first port B), inferable as block RAM.

Test Plan:
- Reset release, wr_valid=0 -> wr_ready=0 for exactly 2400 cycles, then 1. Scan all cells -> every ascii_add = 8'h20.
- Write 8'h41 in IDLE -> cursor_col=1. Drive x=0,y=0 -> ascii_add=8'h41 one cycle later. Drive x=8,y=0 -> 8'h20. Drive x=700 -> 8'h20.
- 80 consecutive printable writes 8'h30 -> cursor_row=1, cursor_col=0. Cells (0,0)..(0,79) read 8'h30.
- Write "AB" then 8'h08 -> cursor_col=1, cell (0,1)=8'h20. Then 8'h08 twice -> cursor_col=0, and the second BS has no effect.
- Move to row 29, fill row 0 with 8'h41, send 8'h0D:
  - wr_ready=0 for exactly 80 cycles.
  - Row 0 reads all 8'h20; cursor=(0,0).
  - wr_valid held high during the clear -> no transfer is lost or duplicated.
- Assert reset_n=0 at clear cycle 1000 -> outputs return to reset values. After release, wr_ready stays 0 for a full 2400 cycles.
